dcache_responder: RTL and testbench

- Data-cache responder on the far side of the memory stage's cache interface.
- Serves two load read ports with a same-cycle hit indication (`data_ready*`, `data_response*`).
- On a miss, runs a fill FSM against backing memory; the pipeline holds the load via its miss flag and retries until the line is present.
- Also accepts retiring stores from the LSQ head: write-through, no-write-allocate.

---
 rtl/dcache_responder_pkg.sv | 18 +
 rtl/dcache_array.sv | 63 ++++++
 rtl/dcache_responder.sv | 119 +++++++++++
 tb/tb_dcache_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_responder_pkg.sv
// Shared types and constants for the dcache responder: address/word types,
// default geometry and the fill/store controller state encoding.
package dcache_responder_pkg;

   localparam int DC_ADDR_W = 32;
   localparam int DC_DATA_W = 32;
   localparam int DC_LINES  = 16;

   typedef logic [DC_ADDR_W-1:0] Address;
   typedef logic [DC_DATA_W-1:0] MemoryWord;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      STORE = 2'd2
   } dcache_state_e;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped valid/tag/data storage with two combinational lookup ports and
// one synchronous write port that either allocates (fill) or updates on hit only (store).
module dcache_array
   import dcache_responder_pkg::*;
#(
   parameter int LINES  = DC_LINES,
   parameter int TAG_W  = 26,
   parameter int DATA_W = DC_DATA_W,
   parameter int IDX_W  = $clog2(LINES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  lk_idx1,
   input  logic [TAG_W-1:0]  lk_tag1,
   output logic              lk_hit1,
   output logic [DATA_W-1:0] lk_data1,
   input  logic [IDX_W-1:0]  lk_idx2,
   input  logic [TAG_W-1:0]  lk_tag2,
   output logic              lk_hit2,
   output logic [DATA_W-1:0] lk_data2,
   input  logic              wr_en,
   input  logic              wr_alloc,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data
);

   logic [LINES-1:0] valid_reg;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];
   logic              wr_commit;

   // A store only touches a line that already holds its tag; a fill always allocates.
   assign wr_commit = wr_en & ~reset &
                      (wr_alloc | (valid_reg[wr_idx] & (tag_mem[wr_idx] == wr_tag)));

   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk) begin
            if (reset) begin
               valid_reg[gi] <= 1'b0;
            end else if (wr_commit && (wr_idx == IDX_W'(gi))) begin
               valid_reg[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_commit) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      lk_hit1  = valid_reg[lk_idx1] & (tag_mem[lk_idx1] == lk_tag1);
      lk_hit2  = valid_reg[lk_idx2] & (tag_mem[lk_idx2] == lk_tag2);
      lk_data1 = lk_hit1 ? data_mem[lk_idx1] : '0;
      lk_data2 = lk_hit2 ? data_mem[lk_idx2] : '0;
   end

endmodule

// File: rtl/dcache_responder.sv
// Data-cache responder: zero-latency dual-port hit lookup, a fill controller for
// load misses and write-through/no-allocate handling of retiring stores.
module dcache_responder
   import dcache_responder_pkg::*;
#(
   parameter int ADDR_W = DC_ADDR_W,
   parameter int DATA_W = DC_DATA_W,
   parameter int LINES  = DC_LINES,
   parameter int IDX_W  = $clog2(LINES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req1,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic              data_ready1,
   output logic [DATA_W-1:0] data_response1,
   input  logic              rd_req2,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic              data_ready2,
   output logic [DATA_W-1:0] data_response2,
   input  logic              st_valid,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   output logic              st_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

   dcache_state_e     state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic              hit1, hit2, miss1, miss2;
   logic [DATA_W-1:0] lk_data1, lk_data2;
   logic              wr_en;

   dcache_array #(
      .LINES (LINES),
      .TAG_W (TAG_W),
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .lk_idx1 (rd_addr1[IDX_W+1:2]),
      .lk_tag1 (rd_addr1[ADDR_W-1:IDX_W+2]),
      .lk_hit1 (hit1),
      .lk_data1(lk_data1),
      .lk_idx2 (rd_addr2[IDX_W+1:2]),
      .lk_tag2 (rd_addr2[ADDR_W-1:IDX_W+2]),
      .lk_hit2 (hit2),
      .lk_data2(lk_data2),
      .wr_en   (wr_en),
      .wr_alloc(state_reg == FILL),
      .wr_idx  (addr_reg[IDX_W+1:2]),
      .wr_tag  (addr_reg[ADDR_W-1:IDX_W+2]),
      .wr_data ((state_reg == FILL) ? mem_rdata : wdata_reg)
   );

   assign data_ready1    = rd_req1 & hit1;
   assign data_ready2    = rd_req2 & hit2;
   assign data_response1 = data_ready1 ? lk_data1 : '0;
   assign data_response2 = data_ready2 ? lk_data2 : '0;
   assign miss1          = rd_req1 & ~hit1;
   assign miss2          = rd_req2 & ~hit2;

   // The request fields come straight from registers, so they stay stable until ack.
   assign mem_req   = (state_reg != IDLE);
   assign mem_we    = (state_reg == STORE);
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign wr_en     = mem_ack & (state_reg != IDLE);

   always_comb begin
      state_next = state_reg;
      st_ready   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (st_valid) begin
               state_next = STORE;
               st_ready   = 1'b1;
            end else if (miss1 || miss2) begin
               state_next = FILL;
            end
         end
         FILL, STORE: begin
            if (mem_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE) begin
            if (st_valid) begin
               addr_reg  <= st_addr & WORD_MASK;
               wdata_reg <= st_data;
            end else if (miss1) begin
               addr_reg  <= rd_addr1 & WORD_MASK;
            end else if (miss2) begin
               addr_reg  <= rd_addr2 & WORD_MASK;
            end
         end
      end
   end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: one task per scenario, inline checks,
// a scripted backing-memory responder.
module tb_dcache_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req1, rd_req2, st_valid, mem_ack;
   logic [31:0] rd_addr1, rd_addr2, st_addr, st_data, mem_rdata;
   logic        data_ready1, data_ready2, st_ready, mem_req, mem_we;
   logic [31:0] data_response1, data_response2, mem_addr, mem_wdata;

   int n_cmp = 0;
   int n_err = 0;

   dcache_responder dut (
      .clk(clk), .reset(reset),
      .rd_req1(rd_req1), .rd_addr1(rd_addr1),
      .data_ready1(data_ready1), .data_response1(data_response1),
      .rd_req2(rd_req2), .rd_addr2(rd_addr2),
      .data_ready2(data_ready2), .data_response2(data_response2),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for a memory request, checks it, holds it for 'delay' cycles, then acks.
   task automatic mem_serve(input string name, input logic exp_we, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input logic [31:0] rdata, input int delay);
      int waited = 0;
      while (!mem_req && waited < 20) begin
         step();
         waited++;
      end
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_err++; $display("FAIL %s req_timeout: mem_req=%b required 1", name, mem_req);
      end
      n_cmp++;
      if (mem_we !== exp_we || mem_addr !== exp_addr || (exp_we && mem_wdata !== exp_wdata)) begin
         n_err++;
         $display("FAIL %s req_fields: we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                  name, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wdata);
      end
      for (int i = 0; i < delay; i++) begin
         step();
         n_cmp++;
         if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== exp_we) begin
            n_err++;
            $display("FAIL %s req_hold: req=%b addr=%h we=%b required 1/%h/%b",
                     name, mem_req, mem_addr, mem_we, exp_addr, exp_we);
         end
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++; $display("FAIL %s req_drop: mem_req=%b required 0", name, mem_req);
      end
      $display("mem txn %s: we=%b addr=%h", name, exp_we, exp_addr);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rd_req1 = 0; rd_req2 = 0; st_valid = 0; mem_ack = 0;
      rd_addr1 = 0; rd_addr2 = 0; st_addr = 0; st_data = 0; mem_rdata = 0;
      repeat (3) step();
      reset = 1'b0;
      rd_req1 = 1'b1; rd_addr1 = 32'h40;
      #1;
      n_cmp++;
      if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0 || st_ready !== 0) begin
         n_err++;
         $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h st_ready=%b required all 0",
                  mem_req, mem_we, mem_addr, mem_wdata, st_ready);
      end
      n_cmp++;
      if (data_ready1 !== 0 || data_response1 !== 0) begin
         n_err++; $display("FAIL reset_lookup: ready=%b resp=%h required 0/0", data_ready1, data_response1);
      end
      rd_req1 = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_cold_miss();
      rd_req1 = 1'b1; rd_addr1 = 32'h40;
      #1;
      n_cmp++;
      if (data_ready1 !== 1'b0) begin
         n_err++; $display("FAIL cold_miss_ready: ready=%b required 0", data_ready1);
      end
      step();
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
         n_err++; $display("FAIL cold_miss_req: req=%b addr=%h we=%b required 1/00000040/0",
                           mem_req, mem_addr, mem_we);
      end
      mem_serve("cold_fill", 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 3);
      n_cmp++;
      if (data_ready1 !== 1'b1 || data_response1 !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL cold_miss_hit: ready=%b resp=%h required 1/deadbeef",
                           data_ready1, data_response1);
      end
      rd_req1 = 1'b0;
   endtask

   task automatic test_store();
      st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h1234;
      #1;
      n_cmp++;
      if (st_ready !== 1'b1) begin
         n_err++; $display("FAIL store_ready_pulse: st_ready=%b required 1", st_ready);
      end
      step();
      n_cmp++;
      if (st_ready !== 1'b0) begin
         n_err++; $display("FAIL store_ready_drop: st_ready=%b required 0", st_ready);
      end
      st_valid = 1'b0;
      mem_serve("store_hit", 1'b1, 32'h40, 32'h1234, 32'h0, 1);
      rd_req2 = 1'b1; rd_addr2 = 32'h40;
      #1;
      n_cmp++;
      if (data_ready2 !== 1'b1 || data_response2 !== 32'h1234) begin
         n_err++; $display("FAIL store_hit_update: ready=%b resp=%h required 1/00001234",
                           data_ready2, data_response2);
      end
      rd_req2 = 1'b0;
      st_valid = 1'b1; st_addr = 32'h80; st_data = 32'h5678;
      step();
      st_valid = 1'b0;
      mem_serve("store_miss", 1'b1, 32'h80, 32'h5678, 32'h0, 0);
      rd_req1 = 1'b1; rd_addr1 = 32'h80;
      rd_req2 = 1'b1; rd_addr2 = 32'h40;
      #1;
      n_cmp++;
      if (data_ready1 !== 1'b0) begin
         n_err++; $display("FAIL store_no_allocate: ready=%b required 0", data_ready1);
      end
      n_cmp++;
      if (data_ready2 !== 1'b1 || data_response2 !== 32'h1234) begin
         n_err++; $display("FAIL store_miss_untouched: ready=%b resp=%h required 1/00001234",
                           data_ready2, data_response2);
      end
      rd_req1 = 1'b0; rd_req2 = 1'b0;
   endtask

   task automatic test_conflict();
      rd_req1 = 1'b1; rd_addr1 = 32'h04;
      step();
      mem_serve("conflict_fill_a", 1'b0, 32'h04, 32'h0, 32'hAAAA0004, 0);
      rd_addr1 = 32'h44;
      step();
      mem_serve("conflict_fill_b", 1'b0, 32'h44, 32'h0, 32'hBBBB0044, 2);
      rd_addr1 = 32'h04;
      rd_req2 = 1'b1; rd_addr2 = 32'h44;
      #1;
      n_cmp++;
      if (data_ready1 !== 1'b0) begin
         n_err++; $display("FAIL conflict_evicted: ready=%b required 0", data_ready1);
      end
      n_cmp++;
      if (data_ready2 !== 1'b1 || data_response2 !== 32'hBBBB0044) begin
         n_err++; $display("FAIL conflict_new: ready=%b resp=%h required 1/bbbb0044",
                           data_ready2, data_response2);
      end
      rd_req1 = 1'b0; rd_req2 = 1'b0;
   endtask

   task automatic test_priority();
      st_valid = 1'b1; st_addr = 32'h500; st_data = 32'h55;
      rd_req1 = 1'b1; rd_addr1 = 32'h200;
      rd_req2 = 1'b1; rd_addr2 = 32'h308;
      #1;
      n_cmp++;
      if (st_ready !== 1'b1) begin
         n_err++; $display("FAIL prio_st_ready: st_ready=%b required 1", st_ready);
      end
      step();
      n_cmp++;
      if (st_ready !== 1'b0) begin
         n_err++; $display("FAIL prio_st_ready_once: st_ready=%b required 0", st_ready);
      end
      st_valid = 1'b0;
      mem_serve("prio_store", 1'b1, 32'h500, 32'h55, 32'h0, 0);
      mem_serve("prio_fill1", 1'b0, 32'h200, 32'h0, 32'h11112222, 1);
      n_cmp++;
      if (data_ready1 !== 1'b1 || data_response1 !== 32'h11112222 || data_ready2 !== 1'b0) begin
         n_err++; $display("FAIL prio_after_fill1: r1=%b d1=%h r2=%b required 1/11112222/0",
                           data_ready1, data_response1, data_ready2);
      end
      mem_serve("prio_fill2", 1'b0, 32'h308, 32'h0, 32'h33334444, 0);
      n_cmp++;
      if (data_ready2 !== 1'b1 || data_response2 !== 32'h33334444) begin
         n_err++; $display("FAIL prio_after_fill2: r2=%b d2=%h required 1/33334444",
                           data_ready2, data_response2);
      end
      rd_req1 = 1'b0; rd_req2 = 1'b0;
   endtask

   task automatic test_dual_miss();
      int extra_reqs = 0;
      rd_req1 = 1'b1; rd_addr1 = 32'h100;
      rd_req2 = 1'b1; rd_addr2 = 32'h100;
      step();
      mem_serve("dual_fill", 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 2);
      n_cmp++;
      if (data_ready1 !== 1'b1 || data_ready2 !== 1'b1 ||
          data_response1 !== 32'hCAFEF00D || data_response2 !== 32'hCAFEF00D) begin
         n_err++; $display("FAIL dual_both_hit: r1=%b r2=%b d1=%h d2=%h required 1/1/cafef00d/cafef00d",
                           data_ready1, data_ready2, data_response1, data_response2);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         if (mem_req) extra_reqs++;
      end
      n_cmp++;
      if (extra_reqs !== 0) begin
         n_err++; $display("FAIL dual_single_read: extra request cycles=%0d required 0", extra_reqs);
      end
      rd_req1 = 1'b0; rd_req2 = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      rd_req1 = 1'b1; rd_addr1 = 32'h40;
      step();
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_err++; $display("FAIL midreset_fill_start: mem_req=%b required 1", mem_req);
      end
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h99999999;
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++; $display("FAIL midreset_req: mem_req=%b required 0", mem_req);
      end
      rd_req1 = 1'b0;
      step();
      reset = 1'b0;
      rd_req1 = 1'b1; rd_addr1 = 32'h40;
      rd_req2 = 1'b1; rd_addr2 = 32'h100;
      #1;
      n_cmp++;
      if (data_ready1 !== 1'b0 || data_ready2 !== 1'b0 || mem_req !== 1'b0) begin
         n_err++; $display("FAIL midreset_invalid: r1=%b r2=%b req=%b required 0/0/0",
                           data_ready1, data_ready2, mem_req);
      end
      rd_req1 = 1'b0; rd_req2 = 1'b0;
      step();
      $display("test_reset_mid_fill done");
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_store();
      test_conflict();
      test_priority();
      test_dual_miss();
      test_reset_mid_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
